// File: rtl/io_bcd_display.sv
`default_nettype none
// ============================================================================
//  Module   : io_bcd_display
//  Purpose  : Multi-cycle double-dabble binary-to-BCD driver for eight
//             active-low seven-segment displays. It holds one newer write
//             while a conversion runs. LEADING_ZERO_BLANK_EN blanks leading
//             zero digits.
//  Revision : 1.0  initial release
// ============================================================================
module io_bcd_display #(
    parameter int DATA_W     = 32,
    parameter int NUM_DIGITS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [7*NUM_DIGITS-1:0] hex_out
);

    localparam int DIG_INT = (DATA_W + 2) / 3;
    localparam int BCD_W   = 4 * DIG_INT;
    localparam int DISP_W  = 4 * NUM_DIGITS;
    localparam int CNT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] C_LAST_SHIFT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   bin_sr_q, bin_sr_d;
    logic [BCD_W-1:0]    bcd_sr_q, bcd_sr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   pend_data_q, pend_data_d;
    logic                pend_vld_q, pend_vld_d;
    logic [DISP_W-1:0]   disp_bcd_q, disp_bcd_d;
    logic                disp_ovf_q, disp_ovf_d;
    logic                done_q, done_d;

    logic [BCD_W-1:0]    w_bcd_adj;
    logic                w_high_nz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bin_sr_q    <= '0;
            bcd_sr_q    <= '0;
            cnt_q       <= '0;
            pend_data_q <= '0;
            pend_vld_q  <= 1'b0;
            disp_bcd_q  <= '0;
            disp_ovf_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_sr_q    <= bin_sr_d;
            bcd_sr_q    <= bcd_sr_d;
            cnt_q       <= cnt_d;
            pend_data_q <= pend_data_d;
            pend_vld_q  <= pend_vld_d;
            disp_bcd_q  <= disp_bcd_d;
            disp_ovf_q  <= disp_ovf_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        w_bcd_adj = bcd_sr_q;
        for (int i = 0; i < DIG_INT; i++) begin
            if (bcd_sr_q[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = bcd_sr_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        bin_sr_d    = bin_sr_q;
        bcd_sr_d    = bcd_sr_q;
        cnt_d       = cnt_q;
        pend_data_d = pend_data_q;
        pend_vld_d  = pend_vld_q;
        disp_bcd_d  = disp_bcd_q;
        disp_ovf_d  = disp_ovf_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    bin_sr_d = in_data;
                    bcd_sr_d = '0;
                    cnt_d    = '0;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                bcd_sr_d = {w_bcd_adj[BCD_W-2:0], bin_sr_q[DATA_W-1]};
                bin_sr_d = {bin_sr_q[DATA_W-2:0], 1'b0};
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == C_LAST_SHIFT) begin
                    state_d = S_DONE;
                end
                // A later write simply replaces whatever was waiting.
                if (in_valid) begin
                    pend_data_d = in_data;
                    pend_vld_d  = 1'b1;
                end
            end
            S_DONE: begin
                disp_bcd_d = DISP_W'(bcd_sr_q);
                disp_ovf_d = 1'b0;
                for (int i = NUM_DIGITS; i < DIG_INT; i++) begin
                    disp_ovf_d = disp_ovf_d | (|bcd_sr_q[4*i +: 4]);
                end
                done_d = 1'b1;
                if (in_valid || pend_vld_q) begin
                    bin_sr_d   = in_valid ? in_data : pend_data_q;
                    bcd_sr_d   = '0;
                    cnt_d      = '0;
                    pend_vld_d = 1'b0;
                    state_d    = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    function automatic logic [6:0] seg_code(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_code = 7'h40;
            4'd1:    seg_code = 7'h79;
            4'd2:    seg_code = 7'h24;
            4'd3:    seg_code = 7'h30;
            4'd4:    seg_code = 7'h19;
            4'd5:    seg_code = 7'h12;
            4'd6:    seg_code = 7'h02;
            4'd7:    seg_code = 7'h78;
            4'd8:    seg_code = 7'h00;
            4'd9:    seg_code = 7'h10;
            default: seg_code = 7'h7F;
        endcase
    endfunction

    // Walk from the top digit down so each digit knows whether anything above it is nonzero.
    always_comb begin
        hex_out   = '0;
        w_high_nz = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_high_nz = w_high_nz | (|disp_bcd_q[4*i +: 4]);
            if (disp_ovf_q) begin
                hex_out[7*i +: 7] = 7'h3F;
`ifdef LEADING_ZERO_BLANK_EN
            end else if ((i > 0) && !w_high_nz) begin
                hex_out[7*i +: 7] = 7'h7F;
`endif
            end else begin
                hex_out[7*i +: 7] = seg_code(disp_bcd_q[4*i +: 4]);
            end
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign overflow = disp_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_io_bcd_display.sv
`default_nettype none
// Directed bench for io_bcd_display: a scoreboard queue holds expected displays,
// popped whenever the DUT pulses done. Expectations follow LEADING_ZERO_BLANK_EN.
module tb_io_bcd_display;

    localparam int DATA_W     = 32;
    localparam int NUM_DIGITS = 8;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    typedef struct {
        logic                    ovf;
        logic [7*NUM_DIGITS-1:0] hex;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    in_valid;
    logic [DATA_W-1:0]       in_data;
    logic                    busy;
    logic                    done;
    logic                    overflow;
    logic [7*NUM_DIGITS-1:0] hex_out;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    io_bcd_display #(.DATA_W(DATA_W), .NUM_DIGITS(NUM_DIGITS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .hex_out  (hex_out)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30;
            4: return 7'h19; 5: return 7'h12; 6: return 7'h02; 7: return 7'h78;
            8: return 7'h00; default: return 7'h10;
        endcase
    endfunction

    function automatic exp_t model(input longint unsigned v);
        exp_t e;
        int   dig[NUM_DIGITS];
        bit   nz = 0;
        longint unsigned x = v;
        e.ovf = (v > 64'd99999999);
        e.hex = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dig[i] = int'(x % 10);
            x = x / 10;
        end
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nz = nz | (dig[i] != 0);
            if (e.ovf)                          e.hex[7*i +: 7] = 7'h3F;
            else if (BLANK_EN && i > 0 && !nz)  e.hex[7*i +: 7] = 7'h7F;
            else                                e.hex[7*i +: 7] = seg(dig[i]);
        end
        return e;
    endfunction

    task automatic check1(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        check1({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check1({tag, "_hex"}, 64'(hex_out), 64'(e.hex));
            check1({tag, "_ovf"}, 64'(overflow), 64'(e.ovf));
        end
    endtask

    // One clock edge, then check busy/done; a done pulse retires a scoreboard entry.
    task automatic step(input logic eb, input logic ed, input string tag);
        @(posedge clk);
        #1;
        check1({tag, "_busy"}, 64'(busy), 64'(eb));
        check1({tag, "_done"}, 64'(done), 64'(ed));
        if (done === 1'b1) pop_compare(tag);
    endtask

    task automatic convert(input logic [DATA_W-1:0] v, input string tag);
        sb.push_back(model(64'(v)));
        in_valid = 1'b1;
        in_data  = v;
        step(1'b1, 1'b0, $sformatf("%s_e0", tag));
        in_valid = 1'b0;
        for (int k = 1; k <= 32; k++) step(1'b1, 1'b0, $sformatf("%s_e%0d", tag, k));
        step(1'b0, 1'b1, $sformatf("%s_e33", tag));
        step(1'b0, 1'b0, $sformatf("%s_e34", tag));
    endtask

    task automatic check_reset_outputs(input string tag);
        exp_t e;
        e = model(64'd0);
        check1({tag, "_busy"}, 64'(busy), 64'd0);
        check1({tag, "_done"}, 64'(done), 64'd0);
        check1({tag, "_ovf"},  64'(overflow), 64'd0);
        check1({tag, "_hex"},  64'(hex_out), 64'(e.hex));
    endtask

    initial begin
        int   ndone;
        exp_t e;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        check1("reset_hex0", 64'(hex_out[6:0]), 64'h40);
        rst_n = 1'b1;
        step(1'b0, 1'b0, "post_reset");

        // Test 1: zero
        convert(32'd0, "t1_zero");

        // Test 2: 12345678 against literal segment codes
        convert(32'd12345678, "t2");
        check1("t2_literal", 64'(hex_out),
               64'({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}));

        // Test 3: overflow boundary
        convert(32'd100000000, "t3_ovf");
        check1("t3_dash", 64'(hex_out), 64'({8{7'h3F}}));
        convert(32'd99999999, "t3_max");
        check1("t3_nines", 64'(hex_out), 64'({8{7'h10}}));
        check1("t3_nines_ovf", 64'(overflow), 64'd0);

        // Test 4: A, B, C with B dropped; busy continuous
        sb.push_back(model(64'd5));
        sb.push_back(model(64'd7));
        in_valid = 1'b1; in_data = 32'd5;
        step(1'b1, 1'b0, "t4_e0");
        in_valid = 1'b0;
        ndone = 0;
        for (int k = 1; k <= 70; k++) begin
            if (k == 5)  begin in_valid = 1'b1; in_data = 32'd6; end
            if (k == 10) begin in_valid = 1'b1; in_data = 32'd7; end
            step(k <= 65, (k == 33) || (k == 66), $sformatf("t4_e%0d", k));
            if (done === 1'b1) ndone++;
            in_valid = 1'b0;
        end
        check1("t4_done_count", 64'(ndone), 64'd2);

        // Test 5: C strobed in A's DONE cycle replaces pending B
        sb.push_back(model(64'd1));
        sb.push_back(model(64'd9));
        in_valid = 1'b1; in_data = 32'd1;
        step(1'b1, 1'b0, "t5_e0");
        in_valid = 1'b0;
        for (int k = 1; k <= 110; k++) begin
            if (k == 5)  begin in_valid = 1'b1; in_data = 32'd6; end
            if (k == 33) begin in_valid = 1'b1; in_data = 32'd9; end
            step(k <= 65, (k == 33) || (k == 66), $sformatf("t5_e%0d", k));
            in_valid = 1'b0;
        end

        // Test 6: reset mid-conversion, displayed value was overflow
        convert(32'hFFFF_FFFF, "t6_max");
        in_valid = 1'b1; in_data = 32'd123;
        step(1'b1, 1'b0, "t6_e0");
        in_valid = 1'b0;
        for (int k = 1; k <= 15; k++) step(1'b1, 1'b0, $sformatf("t6_e%0d", k));
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("t6_async");
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 40; k++) step(1'b0, 1'b0, $sformatf("t6_quiet%0d", k));
        e = model(64'd0);
        check1("t6_hex_after", 64'(hex_out), 64'(e.hex));
        convert(32'd42, "t6_after");

        check1("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
